// File: rtl/rv32i_io_top.sv
// -----------------------------------------------------------------------------
// rv32i_io_top
//
// Memory-mapped IO responder for the RV32I pipeline. It is the target end of
// the memory stage's IO port. Bit 31 address qualification happens upstream,
// so only the word offset addr[7:2] is decoded here.
//
// Register map (byte offsets):
//   0x00 GPIO_OUT   r/w   drives gpio_out
//   0x04 GPIO_IN    ro    gpio_in after a two-flop synchroniser
//   0x08 TIMER      r/w   free-running up-counter; a write loads it instead
//   0x0C TIMER_CMP  r/w   compare value, resets to 0xFFFFFFFF
//   0x10 STATUS     r/w1c bit0 MATCH, bit1 FULL, bit2 EMPTY, bits[5:3] COUNT,
//                         bit6 OVF
//   0x14 TX_DATA    wo    push io_wdata[7:0] into the transmit FIFO
//   other offsets         read 0, writes ignored
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   io_we      write strobe (full-word writes only)
//   io_addr    write word address [31:2]
//   io_wdata   write data
//   io_raddr   read word address [31:2], presented every cycle
//   io_rdata   registered read data for io_raddr of the previous cycle
//   gpio_in    asynchronous external inputs
//   gpio_out   GPIO output register
//   timer_irq  sticky timer-match flag (STATUS.MATCH)
//   tx_data    FIFO head byte
//   tx_valid   FIFO non-empty
//   tx_ready   sink takes the head byte this cycle
// -----------------------------------------------------------------------------
module rv32i_io_top #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_we,
  input  logic [31:2] io_addr,
  input  logic [31:0] io_wdata,
  input  logic [31:2] io_raddr,
  output logic [31:0] io_rdata,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic        timer_irq,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  // Pointer and occupancy widths: pointers wrap naturally at FIFO_DEPTH,
  // the count needs one extra bit to represent "full".
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [5:0] OFF_GPIO_OUT  = 6'h00;
  localparam logic [5:0] OFF_GPIO_IN   = 6'h01;
  localparam logic [5:0] OFF_TIMER     = 6'h02;
  localparam logic [5:0] OFF_TIMER_CMP = 6'h03;
  localparam logic [5:0] OFF_STATUS    = 6'h04;
  localparam logic [5:0] OFF_TX_DATA   = 6'h05;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]   r_gpio_out;
  logic [31:0]   r_sync1;
  logic [31:0]   r_sync2;
  logic [31:0]   r_timer;
  logic [31:0]   r_timer_cmp;
  logic          r_match;
  logic          r_ovf;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_rdata;

  // ---------------------------------------------------------------------------
  // Decode and FIFO control
  // ---------------------------------------------------------------------------
  logic [5:0]  w_wr_off;
  logic [5:0]  w_rd_off;
  logic        w_wr_gpio;
  logic        w_wr_timer;
  logic        w_wr_cmp;
  logic        w_wr_status;
  logic        w_push;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_push_ok;
  logic        w_ovf_set;
  logic        w_match_set;
  logic        w_match_clr;
  logic        w_ovf_clr;
  logic [31:0] w_status;
  logic [31:0] w_rdata_next;

  assign w_wr_off    = io_addr[7:2];
  assign w_rd_off    = io_raddr[7:2];

  assign w_wr_gpio   = io_we && (w_wr_off == OFF_GPIO_OUT);
  assign w_wr_timer  = io_we && (w_wr_off == OFF_TIMER);
  assign w_wr_cmp    = io_we && (w_wr_off == OFF_TIMER_CMP);
  assign w_wr_status = io_we && (w_wr_off == OFF_STATUS);
  assign w_push      = io_we && (w_wr_off == OFF_TX_DATA);

  assign w_full      = (r_count == DEPTH_C);
  assign w_empty     = (r_count == {CW{1'b0}});
  assign w_pop       = !w_empty && tx_ready;

  // A pop frees the head slot in the same edge, so a push into a full FIFO
  // is accepted whenever a pop coincides with it.
  assign w_push_ok   = w_push && (!w_full || w_pop);
  assign w_ovf_set   = w_push && w_full && !w_pop;

  // Equality is checked on the current timer value; MATCH rises one edge later.
  assign w_match_set = (r_timer == r_timer_cmp);
  assign w_match_clr = w_wr_status && io_wdata[0];
  assign w_ovf_clr   = w_wr_status && io_wdata[6];

  assign w_status = {25'd0, r_ovf, r_count, w_empty, w_full, r_match};

  // Read multiplexer: selects the register addressed by io_raddr this cycle.
  always_comb begin
    w_rdata_next = 32'd0;
    case (w_rd_off)
      OFF_GPIO_OUT:  w_rdata_next = r_gpio_out;
      OFF_GPIO_IN:   w_rdata_next = r_sync2;
      OFF_TIMER:     w_rdata_next = r_timer;
      OFF_TIMER_CMP: w_rdata_next = r_timer_cmp;
      OFF_STATUS:    w_rdata_next = w_status;
      default:       w_rdata_next = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Registered read data: one-cycle latency, matching the data RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= 32'd0;
    end else begin
      r_rdata <= w_rdata_next;
    end
  end

  // GPIO output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gpio_out <= 32'd0;
    end else if (w_wr_gpio) begin
      r_gpio_out <= io_wdata;
    end
  end

  // Two-flop synchroniser for the asynchronous GPIO inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 32'd0;
      r_sync2 <= 32'd0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running timer; a software write replaces the increment that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= 32'd0;
    end else if (w_wr_timer) begin
      r_timer <= io_wdata;
    end else begin
      r_timer <= r_timer + 32'd1;
    end
  end

  // Timer compare register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer_cmp <= 32'hFFFF_FFFF;
    end else if (w_wr_cmp) begin
      r_timer_cmp <= io_wdata;
    end
  end

  // Sticky MATCH and OVF flags; a set in the same cycle as a W1C wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_match <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_match <= w_match_set | (r_match & ~w_match_clr);
      r_ovf   <= w_ovf_set   | (r_ovf   & ~w_ovf_clr);
    end
  end

  // FIFO storage: contents need no reset, validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= io_wdata[7:0];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= {PW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign io_rdata  = r_rdata;
  assign gpio_out  = r_gpio_out;
  assign timer_irq = r_match;
  assign tx_valid  = !w_empty;
  // Head entry is stable while stalled because only a pop moves r_rd_ptr.
  assign tx_data   = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_rv32i_io_top.sv
// -----------------------------------------------------------------------------
// tb_rv32i_io_top
//
// Self-checking bench for rv32i_io_top. Directed scenarios check the register
// map, timer wrap/match, FIFO overflow, drain and simultaneous push/pop against
// fixed expected values; a randomized phase compares the DUT every cycle with a
// behavioural model built from plain variables and a byte queue.
// -----------------------------------------------------------------------------
module tb_rv32i_io_top;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_we = 1'b0;
  logic [31:2] io_addr = 30'd0;
  logic [31:0] io_wdata = 32'd0;
  logic [31:2] io_raddr = 30'd0;
  logic [31:0] io_rdata;
  logic [31:0] gpio_in = 32'd0;
  logic [31:0] gpio_out;
  logic        timer_irq;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  always #5 clk = ~clk;

  rv32i_io_top #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .io_we     (io_we),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_raddr  (io_raddr),
    .io_rdata  (io_rdata),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] m_gpio_out, m_s1, m_s2, m_timer, m_cmp, m_rdata;
  logic        m_match, m_ovf;
  logic [7:0]  m_q[$];

  function automatic logic [31:0] model_read(input logic [5:0] off);
    logic [31:0] st;
    int          n;
    n  = m_q.size();
    st = 32'd0;
    st[0]   = m_match;
    st[1]   = (n == 4);
    st[2]   = (n == 0);
    st[5:3] = 3'(n);
    st[6]   = m_ovf;
    case (off)
      6'd0:    return m_gpio_out;
      6'd1:    return m_s2;
      6'd2:    return m_timer;
      6'd3:    return m_cmp;
      6'd4:    return st;
      default: return 32'd0;
    endcase
  endfunction

  // Advance one clock; the model consumes the inputs seen at the edge.
  task automatic step();
    logic [5:0]  woff;
    logic [31:0] n_rd;
    logic        full, pop, push, mset, oset, mclr, oclr;
    woff = io_addr[7:2];
    n_rd = model_read(io_raddr[7:2]);
    full = (m_q.size() == 4);
    pop  = (m_q.size() != 0) && tx_ready;
    push = io_we && (woff == 6'd5);
    mset = (m_timer == m_cmp);
    oset = push && full && !pop;
    mclr = io_we && (woff == 6'd4) && io_wdata[0];
    oclr = io_we && (woff == 6'd4) && io_wdata[6];
    @(posedge clk);
    if (reset) begin
      m_gpio_out = 32'd0; m_s1 = 32'd0; m_s2 = 32'd0; m_timer = 32'd0;
      m_cmp = 32'hFFFF_FFFF; m_rdata = 32'd0; m_match = 1'b0; m_ovf = 1'b0;
      m_q.delete();
    end else begin
      m_rdata = n_rd;
      m_s2 = m_s1;
      m_s1 = gpio_in;
      if (pop) void'(m_q.pop_front());
      if (push && (!full || pop)) m_q.push_back(io_wdata[7:0]);
      if (io_we && woff == 6'd0) m_gpio_out = io_wdata;
      if (io_we && woff == 6'd2) m_timer = io_wdata;
      else m_timer = m_timer + 32'd1;
      if (io_we && woff == 6'd3) m_cmp = io_wdata;
      m_match = mset | (m_match & !mclr);
      m_ovf   = oset | (m_ovf & !oclr);
    end
    #1;
  endtask

  function automatic logic [31:2] io_word(input int byte_off);
    return 30'h2000_0000 | 30'(byte_off >> 2);
  endfunction

  task automatic wr(input int byte_off, input logic [31:0] data);
    io_we    = 1'b1;
    io_addr  = io_word(byte_off);
    io_wdata = data;
    step();
    io_we    = 1'b0;
  endtask

  task automatic rd(input int byte_off, output logic [31:0] data);
    io_raddr = io_word(byte_off);
    step();
    data = io_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_checks++;
    if (gpio_out !== 32'd0) $display("FAIL reset_gpio_out: got %h want %h", gpio_out, 32'd0);
    else n_pass++;
    n_checks++;
    if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid);
    else n_pass++;
    n_checks++;
    if (io_rdata !== 32'd0 || timer_irq !== 1'b0)
      $display("FAIL reset_rdata_irq: got %h/%b want 0/0", io_rdata, timer_irq);
    else n_pass++;
    rd(16, v);
    n_checks++;
    if (v !== 32'h0000_0004) $display("FAIL reset_status: got %h want %h", v, 32'h4);
    else n_pass++;
    rd(12, v);
    n_checks++;
    if (v !== 32'hFFFF_FFFF) $display("FAIL reset_timer_cmp: got %h want %h", v, 32'hFFFFFFFF);
    else n_pass++;
  endtask

  task automatic test_gpio();
    logic [31:0] v, exp;
    wr(0, 32'hA5A5_0F0F);
    n_checks++;
    if (gpio_out !== 32'hA5A5_0F0F) $display("FAIL gpio_out: got %h want %h", gpio_out, 32'hA5A50F0F);
    else n_pass++;
    rd(0, v);
    n_checks++;
    if (v !== 32'hA5A5_0F0F) $display("FAIL gpio_out_read: got %h want %h", v, 32'hA5A50F0F);
    else n_pass++;
    io_raddr = io_word(4);
    gpio_in  = 32'h0000_1234;
    for (int i = 1; i <= 3; i++) begin
      step();
      exp = (i < 3) ? 32'd0 : 32'h0000_1234;
      n_checks++;
      if (io_rdata !== exp) $display("FAIL gpio_in_latency_%0d: got %h want %h", i, io_rdata, exp);
      else n_pass++;
    end
    wr(4, 32'hFFFF_FFFF);
    rd(4, v);
    n_checks++;
    if (v !== 32'h0000_1234) $display("FAIL gpio_in_write_ignored: got %h want %h", v, 32'h1234);
    else n_pass++;
  endtask

  task automatic test_timer();
    logic [31:0] v, t;
    wr(8, 32'h0000_0010);
    rd(8, v);
    n_checks++;
    if (v !== 32'h0000_0010) $display("FAIL timer_load: got %h want %h", v, 32'h10);
    else n_pass++;
    rd(8, v);
    n_checks++;
    if (v !== 32'h0000_0011) $display("FAIL timer_inc: got %h want %h", v, 32'h11);
    else n_pass++;
    wr(8, 32'hFFFF_FFFD);
    wr(12, 32'h0000_0001);
    io_raddr = io_word(8);
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++;
      if (timer_irq !== (k == 4)) $display("FAIL timer_match_%0d: got %b want %b", k, timer_irq, (k == 4));
      else n_pass++;
      if (k == 3) begin
        n_checks++;
        if (io_rdata !== 32'd0) $display("FAIL timer_wrap: got %h want %h", io_rdata, 32'd0);
        else n_pass++;
      end
    end
    wr(16, 32'h0000_0001);
    n_checks++;
    if (timer_irq !== 1'b0) $display("FAIL timer_w1c: got %b want 0", timer_irq);
    else n_pass++;
    t = m_timer;
    wr(12, t + 32'd2);
    step();
    n_checks++;
    if (timer_irq !== 1'b0) $display("FAIL timer_pre_match: got %b want 0", timer_irq);
    else n_pass++;
    wr(16, 32'h0000_0001);
    n_checks++;
    if (timer_irq !== 1'b1) $display("FAIL timer_set_wins: got %b want 1", timer_irq);
    else n_pass++;
    wr(16, 32'h0000_0001);
    n_checks++;
    if (timer_irq !== 1'b0) $display("FAIL timer_w1c_again: got %b want 0", timer_irq);
    else n_pass++;
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] v;
    tx_ready = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b0) $display("FAIL fifo_pre_empty: got %b want 0", tx_valid);
    else n_pass++;
    wr(20, 32'h0000_0041);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41)
      $display("FAIL fifo_first_push: got %b/%h want 1/41", tx_valid, tx_data);
    else n_pass++;
    for (int i = 1; i < 5; i++) wr(20, 32'h0000_0041 + 32'(i));
    rd(16, v);
    n_checks++;
    if (v !== 32'h0000_0062) $display("FAIL fifo_full_ovf_status: got %h want %h", v, 32'h62);
    else n_pass++;
    n_checks++;
    if (tx_data !== 8'h41) $display("FAIL fifo_head_hold: got %h want %h", tx_data, 8'h41);
    else n_pass++;
  endtask

  task automatic test_drain();
    logic [31:0] v;
    logic [7:0]  exp;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = 8'h41 + 8'(i);
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp)
        $display("FAIL drain_%0d: got %b/%h want 1/%h", i, tx_valid, tx_data, exp);
      else n_pass++;
      step();
    end
    n_checks++;
    if (tx_valid !== 1'b0) $display("FAIL drain_empty: got %b want 0", tx_valid);
    else n_pass++;
    tx_ready = 1'b0;
    rd(16, v);
    n_checks++;
    if (v !== 32'h0000_0044) $display("FAIL drain_status: got %h want %h", v, 32'h44);
    else n_pass++;
    wr(16, 32'h0000_0040);
    rd(16, v);
    n_checks++;
    if (v !== 32'h0000_0004) $display("FAIL ovf_w1c: got %h want %h", v, 32'h4);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic [7:0]  exp_q[$];
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(20, 32'h0000_0061 + 32'(i));
    tx_ready = 1'b1;
    wr(20, 32'h0000_0055);
    tx_ready = 1'b0;
    rd(16, v);
    n_checks++;
    if (v !== 32'h0000_0022) $display("FAIL b2b_status: got %h want %h", v, 32'h22);
    else n_pass++;
    exp_q = '{8'h62, 8'h63, 8'h64, 8'h55};
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_q[i])
        $display("FAIL b2b_order_%0d: got %b/%h want 1/%h", i, tx_valid, tx_data, exp_q[i]);
      else n_pass++;
      step();
    end
    n_checks++;
    if (tx_valid !== 1'b0) $display("FAIL b2b_empty: got %b want 0", tx_valid);
    else n_pass++;
    tx_ready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    wr(20, 32'h0000_0077);
    wr(20, 32'h0000_0078);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b0 || gpio_out !== 32'd0)
      $display("FAIL reset_midflight: got %b/%h want 0/0", tx_valid, gpio_out);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] rnd;
    int          r;
    logic [5:0]  off;
    int          errs;
    errs = 0;
    for (int c = 0; c < 600; c++) begin
      rnd = $urandom();
      r   = $urandom_range(0, 9);
      if (r <= 7) off = 6'(r);
      else if (r == 8) off = 6'd5;
      else off = 6'($urandom_range(6, 63));
      io_we    = ($urandom_range(0, 2) == 0);
      io_addr  = {rnd[23:0], off};
      io_wdata = $urandom();
      if ($urandom_range(0, 7) == 0) io_wdata = m_timer + 32'd3;
      rnd      = $urandom();
      io_raddr = {rnd[23:0], 6'($urandom_range(0, 7))};
      tx_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) gpio_in = $urandom();
      step();
      n_checks++;
      if (io_rdata !== m_rdata || gpio_out !== m_gpio_out || timer_irq !== m_match ||
          tx_valid !== (m_q.size() != 0) || (m_q.size() != 0 && tx_data !== m_q[0])) begin
        if (errs < 10)
          $display("FAIL random_cycle_%0d: got rd=%h go=%h irq=%b v=%b d=%h want rd=%h go=%h irq=%b n=%0d",
                   c, io_rdata, gpio_out, timer_irq, tx_valid, tx_data,
                   m_rdata, m_gpio_out, m_match, m_q.size());
        errs++;
      end else n_pass++;
    end
    io_we    = 1'b0;
    tx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_gpio();
    test_timer();
    test_fifo_overflow();
    test_drain();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
